// File: rtl/jump_game_ctrl.sv
// -----------------------------------------------------------------------------
// jump_game_ctrl
//   Game controller and datapath for the jump game. It sequences
//   MENU -> PLAY -> GAME_OVER, divides clk down to a frame tick, and runs the
//   player's vertical jump physics. It also keeps the current score and the
//   best score seen since reset. Every output comes straight from a register.
//
// Ports
//   clk         in   1        system clock
//   resetn      in   1        synchronous, active-low reset
//   go          in   1        level: start / jump / acknowledge
//   collide     in   1        level: obstacle hit, only looked at in PLAY
//   state       out  3        MENU=0 MENU_WAIT=1 PLAY=2 OVER=3 OVER_WAIT=4
//   frame_tick  out  1        one-cycle pulse every TICK_DIV cycles in PLAY
//   player_y    out  Y_W      player height
//   score       out  SCORE_W  frames survived in the current/last game
//   hi_score    out  SCORE_W  best score since reset
//   game_over   out  1        high in OVER and OVER_WAIT
// -----------------------------------------------------------------------------
module jump_game_ctrl #(
  parameter int Y_W      = 8,
  parameter int GROUND_Y = 0,
  parameter int JUMP_VEL = 12,
  parameter int GRAVITY  = 1,
  parameter int TICK_DIV = 833333,
  parameter int SCORE_W  = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               go,
  input  logic               collide,
  output logic [2:0]         state,
  output logic               frame_tick,
  output logic [Y_W-1:0]     player_y,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic               game_over
);

  typedef enum logic [2:0] {
    ST_MENU      = 3'd0,
    ST_MENU_WAIT = 3'd1,
    ST_PLAY      = 3'd2,
    ST_OVER      = 3'd3,
    ST_OVER_WAIT = 3'd4
  } state_t;

  localparam int                      CNT_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]        TICK_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE      = CNT_W'(1);
  localparam logic [Y_W-1:0]          GROUND_C     = Y_W'(GROUND_Y);
  localparam logic signed [Y_W:0]     JUMP_C       = (Y_W+1)'(JUMP_VEL);
  localparam logic signed [Y_W:0]     GRAV_C       = (Y_W+1)'(GRAVITY);
  localparam logic signed [Y_W:0]     VEL_ZERO     = '0;
  localparam logic signed [Y_W+1:0]   Y_GROUND_EXT = $signed({2'b00, GROUND_C});
  localparam logic signed [Y_W+1:0]   Y_MAX_EXT    = $signed({2'b00, {Y_W{1'b1}}});
  localparam logic [Y_W-1:0]          Y_MAX        = {Y_W{1'b1}};
  localparam logic [SCORE_W-1:0]      SCORE_MAX    = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0]      SCORE_ONE    = SCORE_W'(1);

  state_t                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    tick_r;
  logic [Y_W-1:0]          y_r;
  logic signed [Y_W:0]     vel_r;
  logic [SCORE_W-1:0]      score_r;
  logic [SCORE_W-1:0]      hi_r;
  logic                    jump_pend_r;
  logic                    go_d_r;
  logic                    over_r;

  logic signed [Y_W:0]     vel_eff_s;
  logic signed [Y_W:0]     vel_dec_s;
  logic signed [Y_W+1:0]   y_new_s;
  logic                    land_s;
  logic                    ceil_s;
  logic                    grounded_s;
  logic                    go_rise_s;

  assign state      = state_r;
  assign frame_tick = tick_r;
  assign player_y   = y_r;
  assign score      = score_r;
  assign hi_score   = hi_r;
  assign game_over  = over_r;

  // Next-frame physics candidates and the jump-request edge detector.
  always_comb begin
    vel_eff_s = VEL_ZERO;
    if (jump_pend_r) begin
      vel_eff_s = JUMP_C;
    end else begin
      vel_eff_s = vel_r;
    end
    // Two extra bits: one for sign, one so y + vel cannot overflow before clamping.
    y_new_s    = $signed({2'b00, y_r}) + $signed({vel_eff_s[Y_W], vel_eff_s});
    vel_dec_s  = vel_eff_s - GRAV_C;
    land_s     = (vel_eff_s <= VEL_ZERO) && (y_new_s <= Y_GROUND_EXT);
    ceil_s     = (y_new_s > Y_MAX_EXT);
    grounded_s = (y_r == GROUND_C) && (vel_r == VEL_ZERO);
    go_rise_s  = go & ~go_d_r;
  end

  // Game FSM, frame divider, physics and score registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_MENU;
      cnt_r       <= '0;
      tick_r      <= 1'b0;
      y_r         <= GROUND_C;
      vel_r       <= VEL_ZERO;
      score_r     <= '0;
      hi_r        <= '0;
      jump_pend_r <= 1'b0;
      go_d_r      <= 1'b0;
      over_r      <= 1'b0;
    end else begin
      go_d_r <= go;
      tick_r <= 1'b0;
      case (state_r)
        ST_MENU: begin
          cnt_r  <= '0;
          over_r <= 1'b0;
          if (go) begin
            state_r <= ST_MENU_WAIT;
          end else begin
            state_r <= ST_MENU;
          end
        end
        ST_MENU_WAIT: begin
          cnt_r  <= '0;
          over_r <= 1'b0;
          // Waiting for release keeps the starting press from also counting as a jump.
          if (!go) begin
            state_r     <= ST_PLAY;
            score_r     <= '0;
            y_r         <= GROUND_C;
            vel_r       <= VEL_ZERO;
            jump_pend_r <= 1'b0;
          end else begin
            state_r <= ST_MENU_WAIT;
          end
        end
        ST_PLAY: begin
          if (collide) begin
            // A hit wins over a tick in the same cycle: no score, no physics.
            state_r     <= ST_OVER;
            over_r      <= 1'b1;
            cnt_r       <= '0;
            jump_pend_r <= 1'b0;
            if (score_r > hi_r) begin
              hi_r <= score_r;
            end else begin
              hi_r <= hi_r;
            end
          end else begin
            state_r <= ST_PLAY;
            over_r  <= 1'b0;
            if (cnt_r == TICK_LAST) begin
              cnt_r  <= '0;
              tick_r <= 1'b1;
            end else begin
              cnt_r  <= cnt_r + CNT_ONE;
              tick_r <= 1'b0;
            end
            if (tick_r) begin
              if (score_r != SCORE_MAX) begin
                score_r <= score_r + SCORE_ONE;
              end else begin
                score_r <= score_r;
              end
              if (land_s) begin
                y_r   <= GROUND_C;
                vel_r <= VEL_ZERO;
              end else if (ceil_s) begin
                y_r   <= Y_MAX;
                vel_r <= VEL_ZERO;
              end else begin
                y_r   <= y_new_s[Y_W-1:0];
                vel_r <= vel_dec_s;
              end
              // A pending request is consumed here; a fresh press on the ground is kept.
              jump_pend_r <= go_rise_s & grounded_s & ~jump_pend_r;
            end else if (go_rise_s && grounded_s) begin
              jump_pend_r <= 1'b1;
            end else begin
              jump_pend_r <= jump_pend_r;
            end
          end
        end
        ST_OVER: begin
          over_r <= 1'b1;
          if (go) begin
            state_r <= ST_OVER_WAIT;
          end else begin
            state_r <= ST_OVER;
          end
        end
        ST_OVER_WAIT: begin
          if (!go) begin
            state_r <= ST_MENU;
            over_r  <= 1'b0;
          end else begin
            state_r <= ST_OVER_WAIT;
            over_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_MENU;
          over_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jump_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jump_game_ctrl
//   Directed bench for jump_game_ctrl with a short frame (TICK_DIV=4),
//   JUMP_VEL=3 and an 8-bit score. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_jump_game_ctrl;

  logic       clk;
  logic       resetn;
  logic       go;
  logic       collide;
  logic [2:0] state;
  logic       frame_tick;
  logic [7:0] player_y;
  logic [7:0] score;
  logic [7:0] hi_score;
  logic       game_over;

  int n_cmp;
  int n_err;
  int sc;

  jump_game_ctrl #(
    .Y_W      (8),
    .GROUND_Y (0),
    .JUMP_VEL (3),
    .GRAVITY  (1),
    .TICK_DIV (4),
    .SCORE_W  (8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .go         (go),
    .collide    (collide),
    .state      (state),
    .frame_tick (frame_tick),
    .player_y   (player_y),
    .score      (score),
    .hi_score   (hi_score),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are read 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    step();
    go = 1'b0;
    step();
  endtask

  // Stop in the cycle where frame_tick is visible.
  task automatic wait_tick();
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    if (frame_tick !== 1'b1) check_eq("tick_timeout", 0, 1);
  endtask

  task automatic start_game();
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    check_eq("start_state", int'(state), 2);
  endtask

  // One jump from the ground, checking height and score after each tick.
  task automatic run_jump(input int n, input bit noisy);
    int exp_y[8];
    exp_y = '{3, 5, 6, 6, 5, 3, 0, 0};
    pulse_go();
    for (int k = 0; k < n; k++) begin
      wait_tick();
      step();
      sc++;
      check_eq($sformatf("jump_y[%0d]", k), int'(player_y), exp_y[k]);
      check_eq($sformatf("jump_score[%0d]", k), int'(score), sc);
      if (noisy && exp_y[k] != 0) pulse_go();
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    sc      = 0;
    go      = 1'b0;
    collide = 1'b0;
    resetn  = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();

    // Test 1: reset state, menu handshake, frame tick period.
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_y", int'(player_y), 0);
    check_eq("rst_score", int'(score), 0);
    check_eq("rst_hi", int'(hi_score), 0);
    check_eq("rst_over", int'(game_over), 0);
    check_eq("rst_tick", int'(frame_tick), 0);
    go = 1'b1;
    step();
    check_eq("menu_wait1", int'(state), 1);
    step();
    check_eq("menu_wait2", int'(state), 1);
    go = 1'b0;
    step();
    check_eq("play_entry", int'(state), 2);
    check_eq("play_score0", int'(score), 0);
    check_eq("play_tick0", int'(frame_tick), 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check_eq($sformatf("tick_period[%0d]", i), int'(frame_tick), (i % 4 == 0) ? 1 : 0);
    end
    step();
    sc = 2;
    check_eq("score_two_ticks", int'(score), sc);
    check_eq("entry_go_no_jump", int'(player_y), 0);

    // Test 2: clean jump trajectory.
    run_jump(8, 1'b0);
    // Test 3: airborne presses ignored; the next ground press jumps again.
    run_jump(8, 1'b1);
    run_jump(2, 1'b0);

    // Test 6: reset in mid-air (y=5) aborts the game.
    check_eq("midair_y", int'(player_y), 5);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check_eq("abort_state", int'(state), 0);
    check_eq("abort_y", int'(player_y), 0);
    check_eq("abort_score", int'(score), 0);
    check_eq("abort_hi", int'(hi_score), 0);

    // Test 4: collide coincident with a tick at score 7.
    start_game();
    for (int i = 0; i < 7; i++) begin
      wait_tick();
      step();
    end
    check_eq("pre_hit_score", int'(score), 7);
    wait_tick();
    collide = 1'b1;
    step();
    collide = 1'b0;
    check_eq("hit_state", int'(state), 3);
    check_eq("hit_score", int'(score), 7);
    check_eq("hit_hi", int'(hi_score), 7);
    check_eq("hit_over", int'(game_over), 1);
    check_eq("hit_tick", int'(frame_tick), 0);
    go = 1'b1;
    step();
    check_eq("over_wait", int'(state), 4);
    check_eq("over_wait_flag", int'(game_over), 1);
    go = 1'b0;
    step();
    check_eq("back_menu", int'(state), 0);
    check_eq("menu_flag", int'(game_over), 0);
    check_eq("menu_score_hold", int'(score), 7);

    // Lower second game leaves the high score alone.
    start_game();
    for (int i = 0; i < 5; i++) begin
      wait_tick();
      step();
    end
    collide = 1'b1;
    step();
    collide = 1'b0;
    check_eq("g2_state", int'(state), 3);
    check_eq("g2_score", int'(score), 5);
    check_eq("g2_hi", int'(hi_score), 7);
    pulse_go();
    check_eq("g2_menu", int'(state), 0);

    // Test 5: score saturation.
    start_game();
    for (int i = 0; i < 254; i++) begin
      wait_tick();
      step();
    end
    check_eq("sat_254", int'(score), 254);
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      step();
      check_eq($sformatf("sat_255[%0d]", i), int'(score), 255);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
